// File: rtl/bus_pkg.sv
// Shared definitions for the CPU bus responder: FSM encoding and memory map defaults.
package bus_pkg;

   typedef enum logic [1:0] {
      ACCESS   = 2'd0,
      RAM_RD   = 2'd1,
      EXT_WAIT = 2'd2,
      READY    = 2'd3
   } bus_state_t;

   localparam logic [7:0]  BUS_OPEN_DATA   = 8'hFF;
   localparam logic [15:0] RAM_TOP_DEFAULT = 16'h1FFF;

endpackage

// File: rtl/bus_ram.sv
// Single-port work RAM, 2^AW x 8, registered read; contents are never reset.
module bus_ram #(
   parameter int AW = 11
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [2**AW];

   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the 8-bit CPU bus: mirrored work RAM plus a
// req/ack external port with timeout, pacing the CPU through `locked`.
//
// state    | meaning
// ACCESS   | decode the CPU address; start RAM or external access
// RAM_RD   | RAM read data valid, capture into i_data
// EXT_WAIT | ext_req held high, waiting for ack or timeout
// READY    | locked=1 for one cycle, CPU advances
module cpu_bus_responder
   import bus_pkg::*;
#(
   parameter int          RAM_AW  = 11,
   parameter logic [15:0] RAM_TOP = RAM_TOP_DEFAULT,
   parameter int          TO_W    = 8
) (
   input  logic        clock,
   input  logic        resetn,
   output logic        locked,
   input  logic [15:0] address,
   input  logic [7:0]  o_data,
   input  logic        we,
   output logic [7:0]  i_data,
   output logic        ext_req,
   output logic        ext_we,
   output logic [15:0] ext_addr,
   output logic [7:0]  ext_wdata,
   input  logic [7:0]  ext_rdata,
   input  logic        ext_ack,
   output logic        timeout_err
);

   bus_state_t      state, state_nxt;
   logic [TO_W-1:0] to_cnt, to_cnt_nxt;
   logic            locked_nxt, ext_req_nxt, ext_we_nxt, timeout_nxt;
   logic [7:0]      i_data_nxt, ext_wdata_nxt;
   logic [15:0]     ext_addr_nxt;
   logic            ram_sel, ram_we;
   logic [7:0]      ram_q;

   assign ram_sel = (address <= RAM_TOP);

   // Write strobe gated by reset so an aborted cycle cannot disturb RAM contents.
   bus_ram #(.AW(RAM_AW)) u_ram (
      .clock (clock),
      .we    (ram_we & resetn),
      .addr  (address[RAM_AW-1:0]),
      .wdata (o_data),
      .rdata (ram_q)
   );

   always_comb begin
      state_nxt     = state;
      to_cnt_nxt    = to_cnt;
      locked_nxt    = 1'b0;
      timeout_nxt   = 1'b0;
      i_data_nxt    = i_data;
      ext_req_nxt   = ext_req;
      ext_we_nxt    = ext_we;
      ext_addr_nxt  = ext_addr;
      ext_wdata_nxt = ext_wdata;
      ram_we        = 1'b0;
      case (state)
         ACCESS: begin
            if (ram_sel) begin
               if (we) begin
                  ram_we     = 1'b1;
                  locked_nxt = 1'b1;
                  state_nxt  = READY;
               end else begin
                  state_nxt  = RAM_RD;
               end
            end else begin
               ext_addr_nxt  = address;
               ext_wdata_nxt = o_data;
               ext_we_nxt    = we;
               ext_req_nxt   = 1'b1;
               to_cnt_nxt    = '0;
               state_nxt     = EXT_WAIT;
            end
         end
         RAM_RD: begin
            i_data_nxt = ram_q;
            locked_nxt = 1'b1;
            state_nxt  = READY;
         end
         EXT_WAIT: begin
            // Ack has priority over a timeout on the same cycle.
            if (ext_ack) begin
               if (!ext_we) i_data_nxt = ext_rdata;
               ext_req_nxt = 1'b0;
               locked_nxt  = 1'b1;
               state_nxt   = READY;
            end else if (to_cnt == '1) begin
               if (!ext_we) i_data_nxt = BUS_OPEN_DATA;
               ext_req_nxt = 1'b0;
               timeout_nxt = 1'b1;
               locked_nxt  = 1'b1;
               state_nxt   = READY;
            end else begin
               to_cnt_nxt = to_cnt + TO_W'(1);
            end
         end
         READY: begin
            state_nxt = ACCESS;
         end
         default: begin
            state_nxt = ACCESS;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state       <= ACCESS;
         to_cnt      <= '0;
         locked      <= 1'b0;
         timeout_err <= 1'b0;
         i_data      <= 8'h00;
         ext_req     <= 1'b0;
         ext_we      <= 1'b0;
         ext_addr    <= 16'h0000;
         ext_wdata   <= 8'h00;
      end else begin
         state       <= state_nxt;
         to_cnt      <= to_cnt_nxt;
         locked      <= locked_nxt;
         timeout_err <= timeout_nxt;
         i_data      <= i_data_nxt;
         ext_req     <= ext_req_nxt;
         ext_we      <= ext_we_nxt;
         ext_addr    <= ext_addr_nxt;
         ext_wdata   <= ext_wdata_nxt;
      end
   end

endmodule
